// File: rtl/shifter_issue_unit.sv
// shifter_issue_unit: FIFO-buffered issue front-end that feeds a combinational barrel shifter and registers its result
module shifter_issue_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_leftRight,
  input  logic [3:0]       in_shamt,
  input  logic [15:0]      in_sftSrc,
  output logic             sh_leftRight,
  output logic [3:0]       sh_shamt,
  output logic [15:0]      sh_sftSrc,
  input  logic [15:0]      sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [CNT_W-1:0] done_count
);
  localparam int AW = $clog2(DEPTH);
  logic [20:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_empty, w_push, w_cap, w_drain;
  assign w_full   = r_cnt == (AW+1)'(DEPTH);
  assign w_empty  = r_cnt == '0;
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_cap    = !w_empty && (!out_valid || out_ready);
  assign w_drain  = out_valid && out_ready;
  assign {sh_leftRight, sh_shamt, sh_sftSrc} = w_empty ? 21'd0 : r_mem[r_rp];
  // request storage; contents are only observed through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {in_leftRight, in_shamt, in_sftSrc};
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_cap) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_cap);
    end
  end
  // result register, output handshake and saturating completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      done_count <= '0;
    end else begin
      if (w_cap) begin
        out_valid  <= 1'b1;
        out_result <= sh_result;
      end else if (w_drain) begin
        out_valid <= 1'b0;
      end
      if (w_drain && done_count != '1) done_count <= done_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_shifter_issue_unit.sv
// tb_shifter_issue_unit: randomized scoreboard bench for the shifter issue unit
module tb_shifter_issue_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, in_valid = 1'b0, in_lr = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_shamt = '0;
  logic [15:0] in_src = '0;
  logic        in_ready, sh_lr, out_valid;
  logic [3:0]  sh_shamt;
  logic [15:0] sh_src, sh_result, out_result, done_count;
  logic        s_in_ready, s_sh_lr, s_out_valid;
  logic [3:0]  s_sh_shamt, s_done;
  logic [15:0] s_sh_src, s_sh_result, s_out_result;
  assign sh_result   = sh_lr ? sh_src << sh_shamt : sh_src >> sh_shamt;
  assign s_sh_result = s_sh_lr ? s_sh_src << s_sh_shamt : s_sh_src >> s_sh_shamt;
  shifter_issue_unit #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_leftRight(in_lr), .in_shamt(in_shamt), .in_sftSrc(in_src),
    .sh_leftRight(sh_lr), .sh_shamt(sh_shamt), .sh_sftSrc(sh_src), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .done_count(done_count)
  );
  shifter_issue_unit #(.DEPTH(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_leftRight(in_lr), .in_shamt(in_shamt), .in_sftSrc(in_src),
    .sh_leftRight(s_sh_lr), .sh_shamt(s_sh_shamt), .sh_sftSrc(s_sh_src), .sh_result(s_sh_result),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result), .done_count(s_done)
  );
  typedef struct {
    logic        lr;
    logic [3:0]  amt;
    logic [15:0] src;
    logic [15:0] res;
  } req_t;
  req_t        q[$];
  logic [15:0] got[$];
  int          n_tests = 0, n_fail = 0, drained = 0;
  bit          acc, dr;
  function automatic logic [15:0] ref_shift(logic lr, logic [3:0] amt, logic [15:0] src);
    int p = 1 << amt;
    return lr ? 16'((32'(src) * p) % 65536) : 16'(32'(src) / p);
  endfunction
  task automatic tick();
    req_t r;
    @(negedge clk);
    acc = 0;
    dr  = 0;
    if (rst) begin
      q.delete();
      drained = 0;
    end else begin
      if (out_valid && out_ready) begin
        dr = 1;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: got unexpected result %h, required none", out_result);
        end else begin
          r = q.pop_front();
          if (out_result !== r.res) begin
            n_fail++;
            $display("FAIL scoreboard: got %h, required %h", out_result, r.res);
          end
        end
        got.push_back(out_result);
        drained++;
      end
      if (in_valid && in_ready) begin
        acc = 1;
        q.push_back('{in_lr, in_shamt, in_src, ref_shift(in_lr, in_shamt, in_src)});
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic set_rand();
    in_lr    = 1'($urandom);
    in_shamt = 4'($urandom);
    in_src   = 16'($urandom);
  endtask
  task automatic do_reset();
    in_valid  = 0;
    out_ready = 0;
    rst       = 1;
    tick();
    rst = 0;
    #1;
    got.delete();
  endtask
  task automatic drain();
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    n_tests++;
    if ({out_valid, out_result, done_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b res=%h cnt=%0d, required all 0", out_valid, out_result, done_count);
    end
    n_tests++;
    if ({sh_lr, sh_shamt, sh_src} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_sh: got %b %h %h, required all 0", sh_lr, sh_shamt, sh_src);
    end
    rst = 0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
  endtask
  task automatic test_single();
    do_reset();
    out_ready = 1;
    in_lr = 1; in_shamt = 4; in_src = 16'h0001; in_valid = 1;
    tick();
    in_valid = 0;
    n_tests++;
    if (!acc) begin n_fail++; $display("FAIL single_accept: got 0, required 1"); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b, required 0", out_valid); end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_result !== 16'h0010) begin
      n_fail++;
      $display("FAIL single_result: got ov=%b res=%h, required ov=1 res=0010", out_valid, out_result);
    end
    tick();
    n_tests++;
    if (done_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d, required 1", done_count); end
  endtask
  task automatic test_right_zero();
    do_reset();
    out_ready = 1;
    in_lr = 0; in_shamt = 15; in_src = 16'h8000; in_valid = 1;
    tick();
    in_lr = 1; in_shamt = 0; in_src = 16'hA5A5;
    tick();
    drain();
    n_tests++;
    if (got.size() != 2 || got[0] !== 16'h0001 || got[1] !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL right_zero_order: got %0d results, required 0001 then a5a5", got.size());
    end
    n_tests++;
    if (done_count !== 16'd2) begin n_fail++; $display("FAIL right_zero_count: got %0d, required 2", done_count); end
  endtask
  task automatic test_full();
    int n_acc = 0;
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      set_rand();
      tick();
      if (acc) n_acc++;
    end
    n_tests++;
    if (n_acc != 5) begin n_fail++; $display("FAIL full_accepts: got %0d, required 5", n_acc); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b, required 1", out_valid); end
    set_rand();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (acc) begin n_fail++; $display("FAIL full_held: got accepted, required held"); end
      n_tests++;
      if (q.size() < 2 || out_result !== q[0].res || {sh_lr, sh_shamt, sh_src} !== {q[1].lr, q[1].amt, q[1].src}) begin
        n_fail++;
        $display("FAIL full_stall_stable: got res=%h sh=%b/%h/%h", out_result, sh_lr, sh_shamt, sh_src);
      end
    end
    out_ready = 1;
    for (int i = 0; i < 50 && in_valid; i++) begin
      tick();
      if (acc) in_valid = 0;
    end
    drain();
    n_tests++;
    if (got.size() != 6 || done_count !== 16'd6) begin
      n_fail++;
      $display("FAIL full_drain: got %0d results cnt=%0d, required 6", got.size(), done_count);
    end
  endtask
  task automatic test_simultaneous();
    int bad = 0;
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      tick();
    end
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      set_rand();
      tick();
      if (!acc || !dr) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL simul_rate: got %0d stalled cycles, required 0", bad); end
    drain();
    n_tests++;
    if (drained != 23 || done_count !== 16'd23) begin
      n_fail++;
      $display("FAIL simul_total: got %0d results cnt=%0d, required 23", drained, done_count);
    end
  endtask
  task automatic test_reset_mid();
    int leaks = 0;
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      set_rand();
      tick();
    end
    in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_preload: got ov=%b, required 1", out_valid); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_tests++;
    if ({out_valid, done_count} !== 17'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_state: got ov=%b cnt=%0d rdy=%b, required 0 0 1", out_valid, done_count, in_ready);
    end
    n_tests++;
    if ({sh_lr, sh_shamt, sh_src} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_reset_sh: got %b %h %h, required all 0", sh_lr, sh_shamt, sh_src);
    end
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) leaks++;
    end
    n_tests++;
    if (leaks != 0) begin n_fail++; $display("FAIL mid_old_data: got %0d stale results, required 0", leaks); end
  endtask
  task automatic test_saturation();
    do_reset();
    out_ready = 1;
    in_valid  = 1;
    for (int i = 0; i < 20; i++) begin
      set_rand();
      tick();
    end
    drain();
    n_tests++;
    if (done_count !== 16'd20) begin n_fail++; $display("FAIL sat_wide_count: got %0d, required 20", done_count); end
    n_tests++;
    if (s_done !== 4'hF) begin n_fail++; $display("FAIL sat_narrow_count: got %h, required f", s_done); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_right_zero();
    test_full();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
